mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage memory access unit: access sizes, FSM states,
// device window base and the captured bridge request record.
package mem_access_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: alignment check, byte enables, store replication and
// load extract/extend. Shared by the DM path and the bridge path.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  ofs,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  b_sel;
   logic [15:0] h_sel;

   always_comb begin
      aligned   = 1'b1;
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = raw;
      b_sel     = raw[{ofs, 3'b000} +: 8];
      h_sel     = ofs[1] ? raw[31:16] : raw[15:0];
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << ofs;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sign & b_sel[7]}}, b_sel};
         end
         SZ_HALF: begin
            aligned   = ~ofs[0];
            be        = ofs[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sign & h_sel[15]}}, h_sel};
         end
         default: aligned = (ofs == 2'b00); // 11 behaves as word
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: zero-wait DM path plus a stalling bridge path.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT
`ifdef MEM_BUS_TIMEOUT_EN
   , parameter int TIMEOUT = 16
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        PrReq,
   output logic        PrWE,
   output logic [3:0]  PrBE,
   output logic [31:0] PrAddr,
   output logic [31:0] PrWD,
   input  logic        PrAck,
   input  logic [31:0] PrRD,
   output logic        stall,
   output logic [31:0] rdata_W,
   output logic        align_err,
   output logic        bus_err
);

   logic [1:0]  state;
   bus_req_t    cap;
   logic [31:0] rd_q;
   logic        in_idle, in_bus, in_done, is_dev, aligned, go_dm, go_bus;
   logic [1:0]  ln_size, ln_ofs;
   logic        ln_sign;
   logic [31:0] ln_raw, ln_wd, ln_rd;
   logic [3:0]  ln_be;

   assign in_idle = (state == ST_IDLE);
   assign in_bus  = (state == ST_BUS);
   assign in_done = (state == ST_DONE);
   assign is_dev  = (req_addr >= DEV_BASE);
   assign go_dm   = in_idle & req_valid & aligned & ~is_dev;
   assign go_bus  = in_idle & req_valid & aligned & is_dev;

   // In DONE the lane extracts from the captured bridge data, not the DM bus.
   assign ln_size = in_done ? cap.size      : req_size;
   assign ln_ofs  = in_done ? cap.addr[1:0] : req_addr[1:0];
   assign ln_sign = in_done ? cap.sign      : req_sign;
   assign ln_raw  = in_done ? rd_q          : dm_rdata;

   mem_lane_align u_lane (
      .size      (ln_size),
      .ofs       (ln_ofs),
      .sign      (ln_sign),
      .wdata     (req_wdata),
      .raw       (ln_raw),
      .aligned   (aligned),
      .be        (ln_be),
      .wdata_rep (ln_wd),
      .rdata_ext (ln_rd)
   );

   assign dm_we     = ~reset & go_dm & req_we;
   assign dm_be     = ln_be;
   assign dm_addr   = req_addr;
   assign dm_wdata  = ln_wd;
   assign align_err = ~reset & req_valid & ~aligned;
   assign stall     = ~reset & (go_bus | in_bus);

   always_comb begin
      rdata_W = 32'h0;
      if (!reset && ((go_dm && !req_we) || (in_done && !cap.we)))
         rdata_W = ln_rd;
   end

   assign PrReq  = in_bus;
   assign PrWE   = cap.we;
   assign PrBE   = cap.be;
   assign PrAddr = cap.addr;
   assign PrWD   = cap.wdata;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] tmo_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                tmo_cnt <= '0;
      else if (go_bus)          tmo_cnt <= '0;
      else if (in_bus && !PrAck) tmo_cnt <= tmo_cnt + CW'(1);
   end

   assign bus_err = (state == ST_ERR);
`else
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cap   <= '0;
         rd_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (go_bus) begin
               state <= ST_BUS;
               cap   <= '{we: req_we, size: req_size, sign: req_sign,
                          addr: req_addr, be: ln_be, wdata: ln_wd};
            end
            ST_BUS: begin
               if (PrAck) begin
                  state <= ST_DONE;
                  rd_q  <= PrRD;
               end
`ifdef MEM_BUS_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST)
                  state <= ST_ERR;
`endif
            end
            default: state <= ST_IDLE; // DONE and ERR are single-cycle
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: DM vector table plus bridge, reset and
// (with MEM_BUS_TIMEOUT_EN) timeout sequences.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_we, req_sign, pr_ack;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, dm_rdata, pr_rd;
   logic        dm_we, pr_req, pr_we, stall, align_err, bus_err;
   logic [3:0]  dm_be, pr_be;
   logic [31:0] dm_addr, dm_wdata, pr_addr, pr_wd, rdata_w;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .PrReq(pr_req), .PrWE(pr_we),
      .PrBE(pr_be), .PrAddr(pr_addr), .PrWD(pr_wd), .PrAck(pr_ack), .PrRD(pr_rd),
      .stall(stall), .rdata_W(rdata_w), .align_err(align_err), .bus_err(bus_err)
   );

   typedef struct {
      logic        vld, we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr, wdata, rdata;
      logic        e_dm_we;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd;
      logic        e_align;
   } vec_t;

   vec_t tv[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
      req_valid = v; req_we = we; req_size = sz; req_sign = sg;
      req_addr = a; req_wdata = wd;
   endtask

   task automatic run_bus(input string nm, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd, input logic [31:0] e_rd,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
      int  st_n = 0;
      int  pr_n = 0;
      bit  done = 0;
      @(negedge clk);
      drive(1'b1, we, sz, sg, a, wd);
      pr_ack = 1'b0; pr_rd = rd;
      for (int c = 0; c < ack_at + 20 && !done; c++) begin
         #1;
         if (pr_req) begin
            pr_n++;
            if (pr_n == 1) begin
               chk({nm, " PrAddr"}, pr_addr, a);
               chk({nm, " PrWE"}, 32'(pr_we), 32'(we));
               chk({nm, " PrBE"}, 32'(pr_be), 32'(e_be));
               chk({nm, " PrWD"}, pr_wd, e_wd);
               chk({nm, " dm_we in BUS"}, 32'(dm_we), 32'(0));
            end
            if (pr_n == ack_at) pr_ack = 1'b1;
         end
         if (stall) st_n++;
         else if (pr_n > 0) begin
            done = 1;
            chk({nm, " DONE rdata_W"}, rdata_w, e_rd);
            chk({nm, " DONE PrReq"}, 32'(pr_req), 32'(0));
            chk({nm, " DONE bus_err"}, 32'(bus_err), 32'(0));
            pr_ack = 1'b0;
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      pr_ack = 1'b0;
      req_valid = 1'b0;
      chk({nm, " completed"}, 32'(done), 32'(1));
      chk({nm, " stall cycles"}, 32'(st_n), 32'(ack_at + 1));
      chk({nm, " PrReq cycles"}, 32'(pr_n), 32'(ack_at));
      #1;
      chk({nm, " after stall"}, 32'(stall), 32'(0));
      chk({nm, " after PrReq"}, 32'(pr_req), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            vld   we    size   sgn   addr          wdata          rdata          dmwe  be       wd             rd             aerr
      tv[0]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB, 32'h0,         1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0,         1'b0};
      tv[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'hAB00_0000, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFAB, 1'b0};
      tv[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0,         32'h8001_0000, 1'b0, 4'b0000, 32'h0,         32'h0000_8001, 1'b0};
      tv[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
      tv[4]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b1, 4'b1111, 32'h1122_3344, 32'h0,         1'b0};
      tv[5]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0};
      tv[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0};
      tv[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_8001, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,         32'h0000_F000, 1'b0, 4'b0000, 32'h0,         32'h0000_00F0, 1'b0};
      tv[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0,         32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
      tv[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_7EFC, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
      tv[11] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_0055, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b0};
      tv[12] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_7F02, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
      tv[13] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00C3, 32'h0,         1'b1, 4'b0100, 32'hC3C3_C3C3, 32'h0,         1'b0};

      reset = 1'b1; pr_ack = 1'b0; pr_rd = 32'h0; dm_rdata = 32'h0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst PrReq", 32'(pr_req), 32'(0));
      chk("rst PrWE", 32'(pr_we), 32'(0));
      chk("rst PrBE", 32'(pr_be), 32'(0));
      chk("rst PrAddr", pr_addr, 32'h0);
      chk("rst PrWD", pr_wd, 32'h0);
      chk("rst stall", 32'(stall), 32'(0));
      chk("rst bus_err", 32'(bus_err), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i].vld, tv[i].we, tv[i].size, tv[i].sign, tv[i].addr, tv[i].wdata);
         dm_rdata = tv[i].rdata;
         #1;
         chk($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(tv[i].e_dm_we));
         chk($sformatf("v%0d rdata_W", i), rdata_w, tv[i].e_rd);
         chk($sformatf("v%0d align_err", i), 32'(align_err), 32'(tv[i].e_align));
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(0));
         if (tv[i].e_dm_we) begin
            chk($sformatf("v%0d dm_be", i), 32'(dm_be), 32'(tv[i].e_be));
            chk($sformatf("v%0d dm_wdata", i), dm_wdata, tv[i].e_wd);
            chk($sformatf("v%0d dm_addr", i), dm_addr, tv[i].addr);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d PrReq", i), 32'(pr_req), 32'(0));
      end
      @(negedge clk);
      req_valid = 1'b0;

      run_bus("brg word", 1'b0, SZ_WORD, 1'b0, 32'h7F04, 32'h0, 3,
              32'h1234_5678, 32'h1234_5678, 4'b1111, 32'h0);
      run_bus("brg base", 1'b0, SZ_WORD, 1'b0, 32'h7F00, 32'h0, 1,
              32'hA5A5_0F0F, 32'hA5A5_0F0F, 4'b1111, 32'h0);
      run_bus("brg sbyte", 1'b0, SZ_BYTE, 1'b1, 32'h7F01, 32'h0, 2,
              32'h0000_8000, 32'hFFFF_FF80, 4'b0010, 32'h0);
      run_bus("brg store", 1'b1, SZ_HALF, 1'b0, 32'h7F12, 32'h0000_BEEF, 2,
              32'hFFFF_FFFF, 32'h0, 4'b1100, 32'hBEEF_BEEF);

`ifdef MEM_BUS_TIMEOUT_EN
      begin
         int pr_n = 0;
         int st_n = 0;
         int err_n = 0;
         @(negedge clk);
         drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h7F20, 32'h0);
         pr_ack = 1'b0;
         for (int c = 0; c < 24; c++) begin
            #1;
            if (pr_req) pr_n++;
            if (stall) st_n++;
            if (bus_err) begin
               err_n++;
               chk("tmo ERR stall", 32'(stall), 32'(0));
               chk("tmo ERR rdata_W", rdata_w, 32'h0);
               req_valid = 1'b0;
            end
            @(negedge clk);
         end
         chk("tmo PrReq cycles", 32'(pr_n), 32'(16));
         chk("tmo stall cycles", 32'(st_n), 32'(17));
         chk("tmo bus_err pulses", 32'(err_n), 32'(1));
      end
      run_bus("tmo deadline ack", 1'b0, SZ_WORD, 1'b0, 32'h7F24, 32'h0, 16,
              32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0);
`else
      run_bus("no tmo long wait", 1'b0, SZ_WORD, 1'b0, 32'h7F24, 32'h0, 40,
              32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0);
`endif

      // reset in the second BUS cycle
      @(negedge clk);
      drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h7F08, 32'h0);
      pr_ack = 1'b0; pr_rd = 32'h99;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rstbus PrReq before", 32'(pr_req), 32'(1));
      reset = 1'b1;
      #1;
      chk("rstbus PrReq", 32'(pr_req), 32'(0));
      chk("rstbus stall", 32'(stall), 32'(0));
      chk("rstbus PrAddr", pr_addr, 32'h0);
      drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0011, 32'h1);
      #1;
      chk("rst align_err", 32'(align_err), 32'(0));
      drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'h1);
      #1;
      chk("rst dm_we", 32'(dm_we), 32'(0));
      drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0);
      dm_rdata = 32'h5555_AAAA;
      pr_ack = 1'b1;
      #1;
      chk("rst rdata_W", rdata_w, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("post-rst%0d rdata_W", c), rdata_w, 32'h5555_AAAA);
         chk($sformatf("post-rst%0d PrReq", c), 32'(pr_req), 32'(0));
         chk($sformatf("post-rst%0d stall", c), 32'(stall), 32'(0));
         @(negedge clk);
      end
      pr_ack = 1'b0;
      req_valid = 1'b0;
      run_bus("post-rst brg", 1'b0, SZ_HALF, 1'b1, 32'h7F0A, 32'h0, 2,
              32'h8001_0000, 32'hFFFF_8001, 4'b1100, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
